// File: rtl/booth4_pkg.sv
// rtl/booth4_pkg.sv - shared types and constants for the radix-4 Booth sequencer
package booth4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Signed Booth digit encoding (3-bit two's complement, -2..+2)
    localparam logic [2:0] DIGIT_ZERO = 3'b000;
    localparam logic [2:0] DIGIT_POS1 = 3'b001;
    localparam logic [2:0] DIGIT_POS2 = 3'b010;
    localparam logic [2:0] DIGIT_NEG2 = 3'b110;
    localparam logic [2:0] DIGIT_NEG1 = 3'b111;

    // Multiplier bit triplets {b(2i+1), b(2i), b(2i-1)}
    localparam logic [2:0] TRIP_000 = 3'b000;
    localparam logic [2:0] TRIP_001 = 3'b001;
    localparam logic [2:0] TRIP_010 = 3'b010;
    localparam logic [2:0] TRIP_011 = 3'b011;
    localparam logic [2:0] TRIP_100 = 3'b100;
    localparam logic [2:0] TRIP_101 = 3'b101;
    localparam logic [2:0] TRIP_110 = 3'b110;
    localparam logic [2:0] TRIP_111 = 3'b111;

    // Triplet to signed digit, used where a numeric digit is wanted rather than strobes
    function automatic logic [2:0] triplet_digit(input logic [2:0] trip);
        logic [2:0] dig;
        dig = DIGIT_ZERO;
        case (trip)
            TRIP_001, TRIP_010: dig = DIGIT_POS1;
            TRIP_011:           dig = DIGIT_POS2;
            TRIP_100:           dig = DIGIT_NEG2;
            TRIP_101, TRIP_110: dig = DIGIT_NEG1;
            default:            dig = DIGIT_ZERO;
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/booth4_if.sv
// rtl/booth4_if.sv - start/done handshake and datapath strobes; BOOTH_STATUS_EN adds debug status
interface booth4_if #(
    parameter int WIDTH = 8
);
    localparam int ITER = WIDTH / 2;
    localparam int CW   = $clog2(ITER);

    logic             start;
    logic [WIDTH-1:0] mplier;
    logic             busy;
    logic             done;
    logic             ld;
    logic             shift_en;
    logic             sel_zero;
    logic             sel_double;
    logic             sel_neg;
`ifdef BOOTH_STATUS_EN
    logic [CW-1:0]    dbg_cnt;
    logic [2:0]       dbg_digit;

    modport master (
        output start, mplier,
        input  busy, done, ld, shift_en, sel_zero, sel_double, sel_neg, dbg_cnt, dbg_digit
    );
    modport slave (
        input  start, mplier,
        output busy, done, ld, shift_en, sel_zero, sel_double, sel_neg, dbg_cnt, dbg_digit
    );
`else
    modport master (
        output start, mplier,
        input  busy, done, ld, shift_en, sel_zero, sel_double, sel_neg
    );
    modport slave (
        input  start, mplier,
        output busy, done, ld, shift_en, sel_zero, sel_double, sel_neg
    );
`endif

endinterface

// File: rtl/booth4_recoder.sv
// rtl/booth4_recoder.sv - combinational radix-4 Booth triplet to select strobes
module booth4_recoder
    import booth4_pkg::*;
(
    input  logic [2:0] triplet,
    output logic       sel_zero,
    output logic       sel_double,
    output logic       sel_neg
);

    // Decode the triplet into zero/double/negate strobes for the operand muxes
    always_comb begin
        sel_zero   = 1'b0;
        sel_double = 1'b0;
        sel_neg    = 1'b0;
        case (triplet)
            TRIP_000, TRIP_111: sel_zero = 1'b1;
            TRIP_001, TRIP_010: ;
            TRIP_011:           sel_double = 1'b1;
            TRIP_100: begin
                sel_double = 1'b1;
                sel_neg    = 1'b1;
            end
            TRIP_101, TRIP_110: sel_neg = 1'b1;
            default:            sel_zero = 1'b1;
        endcase
    end

endmodule

// File: rtl/booth4_ctrl.sv
// rtl/booth4_ctrl.sv - radix-4 Booth multiplier sequencer/recoder; BOOTH_STATUS_EN adds dbg_cnt/dbg_digit
module booth4_ctrl
    import booth4_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ITER  = WIDTH / 2
) (
    input  logic     clk,
    input  logic     rst,
    booth4_if.slave  bus
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    state_e          state_q, state_d;
    logic [WIDTH:0]  q_q, q_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rec_zero, rec_double, rec_neg;

    // The low triplet of the shift register is always the digit being issued this cycle
    booth4_recoder u_recoder (
        .triplet    (q_q[2:0]),
        .sel_zero   (rec_zero),
        .sel_double (rec_double),
        .sel_neg    (rec_neg)
    );

    // Next-state, shift register/counter update and state-decoded outputs
    always_comb begin
        state_d        = state_q;
        q_d            = q_q;
        cnt_d          = cnt_q;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.ld         = 1'b0;
        bus.shift_en   = 1'b0;
        bus.sel_zero   = 1'b0;
        bus.sel_double = 1'b0;
        bus.sel_neg    = 1'b0;
        case (state_q)
            IDLE: begin
                // mplier is only valid in the accept cycle, so capture it here
                if (bus.start) begin
                    state_d = LOAD;
                    q_d     = {bus.mplier, 1'b0};
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                bus.busy = 1'b1;
                bus.ld   = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                bus.busy       = 1'b1;
                bus.shift_en   = 1'b1;
                bus.sel_zero   = rec_zero;
                bus.sel_double = rec_double;
                bus.sel_neg    = rec_neg;
                q_d            = {q_q[WIDTH], q_q[WIDTH], q_q[WIDTH:2]};
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, multiplier shift register and digit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BOOTH_STATUS_EN
    logic [CW-1:0] dbg_cnt_q, dbg_cnt_d;
    logic [2:0]    dbg_digit_q, dbg_digit_d;

    // Status is computed from next-cycle values so the registered copy lines up with RUN
    always_comb begin
        dbg_cnt_d   = '0;
        dbg_digit_d = DIGIT_ZERO;
        if (state_d == RUN) begin
            dbg_cnt_d   = cnt_d;
            dbg_digit_d = triplet_digit(q_d[2:0]);
        end
    end

    // Debug status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_cnt_q   <= '0;
            dbg_digit_q <= DIGIT_ZERO;
        end else begin
            dbg_cnt_q   <= dbg_cnt_d;
            dbg_digit_q <= dbg_digit_d;
        end
    end

    assign bus.dbg_cnt   = dbg_cnt_q;
    assign bus.dbg_digit = dbg_digit_q;
`endif

endmodule
